// File: rtl/mux2x5_if.sv
// Bus bundle for the 2:1 register-address mux: select inputs, load enable,
// and both the combinational and registered results.
interface mux2x5_if #(
   parameter int unsigned Width = 5
);
   logic [Width-1:0] a0;
   logic [Width-1:0] a1;
   logic             s;
   logic             en;
   logic [Width-1:0] y;
   logic [Width-1:0] y_r;

   modport master (
      output a0,
      output a1,
      output s,
      output en,
      input  y,
      input  y_r
   );

   modport slave (
      input  a0,
      input  a1,
      input  s,
      input  en,
      output y,
      output y_r
   );
endinterface

// File: rtl/mux2x5.sv
// Two-input register-address mux with a zero-latency output and a
// load-enabled registered copy for pipeline-stage use.
module mux2x5 #(
   parameter int unsigned Width = 5
) (
   input  logic         clk,
   input  logic         rst,
   mux2x5_if.slave      bus
);

   logic [Width-1:0] y_comb;
   logic [Width-1:0] y_r_d;
   logic [Width-1:0] y_r_q;

   // An if (rather than ?:) makes an unknown select fall through to a0.
   always_comb begin
      y_comb = bus.a0;
      if (bus.s == 1'b1) begin
         y_comb = bus.a1;
      end
   end

   always_comb begin
      y_r_d = y_r_q;
      if (bus.en) begin
         y_r_d = y_comb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_r_q <= '0;
      end else begin
         y_r_q <= y_r_d;
      end
   end

   assign bus.y   = y_comb;
   assign bus.y_r = y_r_q;

endmodule

// File: tb/tb_mux2x5.sv
// Directed and randomised checks of the combinational mux output and the
// reset/enable behaviour of its registered copy.
module tb_mux2x5;

   localparam int unsigned Width = 5;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   mux2x5_if #(.Width(Width)) bus ();

   mux2x5 #(.Width(Width)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [Width-1:0] got,
                        input logic [Width-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [Width-1:0] exp_y;
   logic [Width-1:0] model_q;
   logic             r_s;
   logic             r_en;
   logic             r_rst;
   logic [Width-1:0] r_a0;
   logic [Width-1:0] r_a1;

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b1;
      bus.a0  = '0;
      bus.a1  = '0;
      bus.s   = 1'b0;
      bus.en  = 1'b0;
      tick();
      check("reset_yr", bus.y_r, 5'b00000);

      // Combinational vectors
      rst = 1'b0;
      bus.a0 = 5'b00000; bus.a1 = 5'b00000; bus.s = 1'b0; #1;
      check("t1_zero", bus.y, 5'b00000);
      bus.a0 = 5'b11111; bus.a1 = 5'b00000; bus.s = 1'b1; #1;
      check("t2_a1_wins", bus.y, 5'b00000);
      bus.a0 = 5'b10101; bus.a1 = 5'b01010; bus.s = 1'b0; #1;
      check("t3_sel_a0", bus.y, 5'b10101);
      bus.s = 1'b1; #1;
      check("t3_sel_a1", bus.y, 5'b01010);

      // Registered path
      rst = 1'b1; bus.en = 1'b1;
      tick();
      check("t4_rst", bus.y_r, 5'b00000);
      rst = 1'b0; bus.en = 1'b1; bus.a0 = 5'b10101; bus.s = 1'b0;
      #1;
      check("t4_pre_edge", bus.y_r, 5'b00000);
      tick();
      check("t4_load", bus.y_r, 5'b10101);

      bus.en = 1'b0; bus.s = 1'b1; #1;
      check("t5_y_changed", bus.y, 5'b01010);
      tick();
      check("t5_hold", bus.y_r, 5'b10101);
      tick();
      check("t5_hold2", bus.y_r, 5'b10101);
      rst = 1'b1; bus.en = 1'b1;
      tick();
      check("t5_rst_over_en", bus.y_r, 5'b00000);
      bus.a0 = 5'b00111; bus.s = 1'b0; #1;
      check("t5_y_in_rst", bus.y, 5'b00111);
      bus.a1 = 5'b11000; bus.s = 1'b1; #1;
      check("t5_y_in_rst_a1", bus.y, 5'b11000);
      rst = 1'b0;

      // Random traffic against a reference model
      bus.en = 1'b0;
      tick();
      model_q = 5'b00000;
      check("t6_start", bus.y_r, model_q);
      for (int i = 0; i < 1000; i++) begin
         r_a0  = Width'($urandom);
         r_a1  = Width'($urandom);
         r_s   = 1'($urandom);
         r_en  = 1'($urandom);
         r_rst = ($urandom_range(0, 31) == 0);
         bus.a0 = r_a0; bus.a1 = r_a1; bus.s = r_s; bus.en = r_en; rst = r_rst;
         exp_y = r_s ? r_a1 : r_a0;
         #1;
         check("t6_y", bus.y, exp_y);
         if (r_rst) begin
            model_q = '0;
         end else if (r_en) begin
            model_q = exp_y;
         end
         tick();
         check("t6_yr", bus.y_r, model_q);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
